// File: rtl/mod_counter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mod_counter_pkg : shared encodings for the modulo counter       |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package mod_counter_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
endpackage : mod_counter_pkg
`default_nettype wire

// File: rtl/mod_counter_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mod_counter_if : control/data bundle of the modulo counter      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             LOAD;
  logic             UD;
  logic             MODE;
  logic [WIDTH-1:0] DATA;
  logic [WIDTH-1:0] MAXV;
  logic [WIDTH-1:0] DOUT;
  logic             COUT;
  logic             SAT;

  modport master (
    output EN, LOAD, UD, MODE, DATA, MAXV,
    input  DOUT, COUT, SAT
  );

  modport slave (
    input  EN, LOAD, UD, MODE, DATA, MAXV,
    output DOUT, COUT, SAT
  );
endinterface : mod_counter_if
`default_nettype wire

// File: rtl/mod_counter_step.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mod_counter_step : next count, boundary and saturate flags      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module mod_counter_step
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] dout,
  input  logic             ud,
  input  logic             mode,
  input  logic [WIDTH-1:0] maxv,
  output logic [WIDTH-1:0] nxt,
  output logic             bnd,
  output logic             sat
);
  localparam logic [WIDTH-1:0] c_one = 1;

  logic w_sat_mode;
  assign w_sat_mode = (mode == MODE_SAT);

  always_comb begin
    nxt = dout;
    bnd = 1'b0;
    sat = 1'b0;
    if (ud == DIR_UP) begin
      // ">=" also catches a count left above a freshly lowered MAXV
      if (dout >= maxv) begin
        bnd = 1'b1;
        sat = w_sat_mode;
        nxt = w_sat_mode ? maxv : '0;
      end else begin
        nxt = dout + c_one;
      end
    end else begin
      if (dout > maxv) begin
        bnd = 1'b1;
        sat = w_sat_mode;
        nxt = maxv;
      end else if (dout == '0) begin
        bnd = 1'b1;
        sat = w_sat_mode;
        nxt = w_sat_mode ? '0 : maxv;
      end else begin
        nxt = dout - c_one;
      end
    end
  end
endmodule : mod_counter_step
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mod_counter : up/down counter over 0..MAXV, wrap or saturate    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         CLK,
  input  logic         RST,
  mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] c_rst_val = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_dout;
  logic             r_cout;
  logic             r_sat;

  logic [WIDTH-1:0] w_nxt;
  logic             w_bnd;
  logic             w_sat;
  logic [WIDTH-1:0] w_load_val;

  mod_counter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .dout (r_dout),
    .ud   (bus.UD),
    .mode (bus.MODE),
    .maxv (bus.MAXV),
    .nxt  (w_nxt),
    .bnd  (w_bnd),
    .sat  (w_sat)
  );

  // Loads are clamped so the count never starts outside 0..MAXV
  assign w_load_val = (bus.DATA > bus.MAXV) ? bus.MAXV : bus.DATA;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dout <= c_rst_val;
      r_cout <= 1'b0;
      r_sat  <= 1'b0;
    end else if (bus.LOAD) begin
      r_dout <= w_load_val;
      r_cout <= 1'b0;
      r_sat  <= 1'b0;
    end else if (bus.EN) begin
      r_dout <= w_nxt;
      r_cout <= w_bnd;
      r_sat  <= w_sat;
    end else begin
      r_cout <= 1'b0;
      r_sat  <= 1'b0;
    end
  end

  assign bus.DOUT = r_dout;
  assign bus.COUT = r_cout;
  assign bus.SAT  = r_sat;
endmodule : mod_counter
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_mod_counter : directed vector bench, WIDTH=4, RST_VAL=3      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_mod_counter;
  logic CLK;
  logic RST;

  int n_checks = 0;
  int n_fail   = 0;

  mod_counter_if #(.WIDTH(4)) bus ();

  mod_counter #(
    .WIDTH   (4),
    .RST_VAL (3)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic       ud;
    logic       mode;
    logic [3:0] data;
    logic [3:0] maxv;
    logic [3:0] dout;
    logic       cout;
    logic       sat;
  } vec_t;

  vec_t q[$];

  function automatic vec_t mk(input logic rst, input logic load, input logic en,
                              input logic ud, input logic mode,
                              input logic [3:0] data, input logic [3:0] maxv,
                              input logic [3:0] dout, input logic cout, input logic sat);
    vec_t v;
    v.rst = rst; v.load = load; v.en = en; v.ud = ud; v.mode = mode;
    v.data = data; v.maxv = maxv; v.dout = dout; v.cout = cout; v.sat = sat;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    RST      = v.rst;
    bus.LOAD = v.load;
    bus.EN   = v.en;
    bus.UD   = v.ud;
    bus.MODE = v.mode;
    bus.DATA = v.data;
    bus.MAXV = v.maxv;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input vec_t v);
    check({name, " DOUT"}, int'(bus.DOUT), int'(v.dout));
    check({name, " COUT"}, int'(bus.COUT), int'(v.cout));
    check({name, " SAT"},  int'(bus.SAT),  int'(v.sat));
  endtask

  initial begin
    vec_t v;
    RST = 1'b1; bus.LOAD = 1'b0; bus.EN = 1'b0; bus.UD = 1'b1;
    bus.MODE = 1'b0; bus.DATA = '0; bus.MAXV = 4'd15;

    //              rst load en ud mode data maxv  dout cout sat
    q.push_back(mk(1, 0, 1, 1, 0, 4'd0,  4'd0,  4'd3,  0, 0)); // reset value
    q.push_back(mk(0, 1, 0, 0, 0, 4'd2,  4'd9,  4'd2,  0, 0));
    q.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd9,  4'd1,  0, 0)); // down wrap 1,0,9,8
    q.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd9,  4'd0,  0, 0));
    q.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd9,  4'd9,  1, 0));
    q.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd9,  4'd8,  0, 0));
    q.push_back(mk(0, 1, 1, 1, 0, 4'd12, 4'd9,  4'd9,  0, 0)); // clamped load beats EN
    q.push_back(mk(0, 1, 0, 1, 1, 4'd8,  4'd9,  4'd8,  0, 0));
    q.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd9,  4'd9,  0, 0)); // up saturate
    q.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd9,  4'd9,  1, 1));
    q.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd9,  4'd9,  1, 1));
    q.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd9,  4'd9,  1, 1));
    q.push_back(mk(0, 0, 0, 1, 1, 4'd0,  4'd9,  4'd9,  0, 0)); // idle clears flags
    q.push_back(mk(0, 1, 0, 1, 0, 4'd7,  4'd15, 4'd7,  0, 0));
    q.push_back(mk(0, 0, 1, 1, 0, 4'd0,  4'd5,  4'd0,  1, 0)); // MAXV lowered, up
    q.push_back(mk(0, 1, 0, 1, 0, 4'd7,  4'd15, 4'd7,  0, 0));
    q.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd5,  4'd5,  1, 0)); // MAXV lowered, down
    q.push_back(mk(0, 1, 0, 0, 1, 4'd7,  4'd15, 4'd7,  0, 0));
    q.push_back(mk(0, 0, 1, 0, 1, 4'd0,  4'd5,  4'd5,  1, 1)); // SAT follows MODE
    q.push_back(mk(0, 0, 1, 0, 1, 4'd0,  4'd5,  4'd4,  0, 0));
    q.push_back(mk(0, 0, 1, 1, 0, 4'd0,  4'd0,  4'd0,  1, 0)); // MAXV=0
    q.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd0,  4'd0,  1, 0));
    q.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd0,  4'd0,  1, 1));
    q.push_back(mk(0, 0, 1, 0, 1, 4'd0,  4'd9,  4'd0,  1, 1)); // down saturate at 0
    q.push_back(mk(0, 1, 0, 1, 0, 4'd15, 4'd15, 4'd15, 0, 0));
    q.push_back(mk(1, 0, 1, 1, 0, 4'd0,  4'd15, 4'd3,  0, 0)); // reset beats boundary
    q.push_back(mk(0, 0, 1, 1, 0, 4'd0,  4'd15, 4'd4,  0, 0));
    q.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd15, 4'd3,  0, 0));

    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      check_vec($sformatf("vec%0d", i), q[i]);
      if (i == 0)
        check("no X after reset", int'($isunknown({bus.DOUT, bus.COUT, bus.SAT})), 0);
    end

    // Full-range wrap from 0: 1..15, 0, 1 with COUT only on the wrap
    drive(mk(0, 1, 0, 1, 0, 4'd0, 4'd15, 4'd0, 0, 0));
    check("load0 DOUT", int'(bus.DOUT), 0);
    for (int k = 0; k < 17; k++) begin
      int exp_d;
      exp_d = (k + 1) % 16;
      v = mk(0, 0, 1, 1, 0, 4'd0, 4'd15, 4'(exp_d), (exp_d == 0), 0);
      drive(v);
      check_vec($sformatf("wrap%0d", k), v);
    end

    // Reset held over several enabled cycles, then counting resumes
    drive(mk(1, 0, 1, 1, 0, 4'd0, 4'd15, 4'd3, 0, 0));
    drive(mk(1, 0, 1, 1, 0, 4'd0, 4'd15, 4'd3, 0, 0));
    check("rst hold DOUT", int'(bus.DOUT), 3);
    drive(mk(0, 0, 1, 1, 0, 4'd0, 4'd15, 4'd4, 0, 0));
    check("rst resume DOUT", int'(bus.DOUT), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule : tb_mod_counter
`default_nettype wire

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter RST_VAL, default 0, giving the count value loaded by reset (must be below 2^WIDTH).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port CLK  input  1  clock; all state changes on its rising edge.
REQ-005 Port RST  input  1  synchronous active-high reset.
REQ-006 Port EN  input  1  count enable; no step when low.
REQ-007 Port LOAD  input  1  synchronous parallel load of DATA.
REQ-008 Port UD  input  1  direction: 1 = up, 0 = down.
REQ-009 Port MODE  input  1  boundary mode: 0 = wrap, 1 = saturate.
REQ-010 Port DATA  input  WIDTH  parallel load value.
REQ-011 Port MAXV  input  WIDTH  terminal value; the counting range is 0..MAXV inclusive.
REQ-012 Port DOUT  output  WIDTH  registered count.
REQ-013 Port COUT  output  1  registered one-cycle boundary pulse.
REQ-014 Port SAT  output  1  registered level: high while the counter is held at a boundary in saturate mode.

Function
REQ-015 Priority SHALL be RST > LOAD > EN; when all three are low, DOUT holds and COUT and SAT go to 0.
REQ-016 LOAD SHALL set DOUT to min(DATA, MAXV) and clear COUT and SAT; EN and UD are ignored in that cycle.
REQ-017 Step up (EN=1, UD=1, DOUT<MAXV) SHALL give DOUT+1 with COUT=0 and SAT=0.
REQ-018 Step down (EN=1, UD=0, 0<DOUT<=MAXV) SHALL give DOUT-1 with COUT=0 and SAT=0.
REQ-019 Up-boundary (EN=1, UD=1, DOUT>=MAXV) in wrap mode SHALL give DOUT=0 and COUT=1.
REQ-020 Up-boundary in saturate mode SHALL give DOUT=MAXV, COUT=1 and SAT=1.
REQ-021 Down-boundary (EN=1, UD=0, DOUT=0) in wrap mode SHALL give DOUT=MAXV and COUT=1.
REQ-022 Down-boundary in saturate mode SHALL hold DOUT=0 with COUT=1 and SAT=1.
REQ-023 If DOUT>MAXV (MAXV lowered mid-run) and a down-step is enabled, the next value SHALL be MAXV with COUT=1, and SAT=MODE.
REQ-024 COUT SHALL be high for exactly one cycle per boundary step; in saturate mode it stays high on every enabled cycle spent pushing against the boundary.
REQ-025 With MAXV=0 the counter SHALL stay at 0 and every enabled step SHALL be a boundary step.
REQ-026 All arithmetic SHALL be modulo 2^WIDTH unsigned, with no intermediate overflow; MAXV = 2^WIDTH-1 gives full-range operation.
REQ-027 The latency from a control input to DOUT, COUT and SAT SHALL be one clock.
REQ-028 MODE, UD and MAXV MAY change on any cycle and SHALL take effect on the next edge.

Reset
REQ-029 While RST=1 at an edge, DOUT SHALL become RST_VAL, COUT 0 and SAT 0, regardless of the other inputs.
REQ-030 Reset asserted mid-count SHALL discard any pending boundary pulse; counting resumes on the first edge after RST falls.
REQ-031 No output SHALL be X after the first reset edge.

Structure
REQ-032 Package mod_counter_pkg SHALL hold the constants MODE_WRAP=0, MODE_SAT=1, DIR_UP=1 and DIR_DOWN=0.
REQ-033 A combinational sub-module mod_counter_step SHALL compute the next value, the boundary flag and the saturate flag from (DOUT, UD, MODE, MAXV).
REQ-034 The top level SHALL hold only the registers and the priority logic.

Verification
REQ-035 WIDTH=4, MAXV=15, wrap, UD=1, EN=1 from 0 -> DOUT 0..15,0; COUT high only in the cycle DOUT=0 after 15.
REQ-036 WIDTH=4, MAXV=9, wrap, UD=0 from 2 -> DOUT 1,0,9,8; COUT high alongside the first 9.
REQ-037 MAXV=9, saturate, UD=1 from 8 for 4 cycles -> DOUT 9,9,9,9; COUT and SAT high for the last 3 cycles.
REQ-038 LOAD=1, DATA=12, MAXV=9 -> DOUT=9; LOAD and EN both high -> load wins.
REQ-039 DOUT=7, MAXV changed to 5, UD=1 wrap -> DOUT 0, COUT=1; UD=0 -> DOUT 5, COUT=1.
REQ-040 RST=1 during an up-boundary cycle with RST_VAL=3 -> DOUT=3, COUT=0, SAT=0 on that edge.
